ni_ejector: RTL and testbench
=============================

Name: ni_ejector

Overview:
- Synchronous receiver at the local ejection end of a router.
- Accepts flits from the router local output port: 1-of-4 QDI data, one-hot flit type and one-hot VC, 4-phase ack, per-VC 4-phase credit return.
- Decodes each flit to binary, buffers it and presents it to the clocked network interface over valid/ready.
- Returns one VC credit per flit consumed.

Parameters:
- DW, 32, binary flit payload width (even).
- SCN, DW/2, number of 1-of-4 groups.
- FT, 3, flit type width, one-hot (bit0 head, bit1 body, bit2 tail).
- VCN, 1, number of virtual channels, one-hot.
- DEPTH, 4, flit FIFO depth (power of 2, >=2).

Ports:
- clk, input, 1, clock.
- rst, input, 1, asynchronous active-high reset.
- di0, di1, di2, di3, input, SCN each, 1-of-4 data rails; group i = {di3[i],di2[i],di1[i],di0[i]}.
- dift, input, FT, flit type rails.
- divc, input, VCN, VC rails.
- dia, output, 1, data ack (4-phase).
- dic, output, VCN, credit request per VC (4-phase).
- dica, input, VCN, credit ack per VC.
- fdata, output, DW, decoded payload.
- fft, output, FT, flit type.
- fvc, output, VCN, VC.
- fvalid, output, 1, flit available.
- fready, input, 1, consumer accepts the flit when fvalid and fready are both high.

Behaviour:
- All async inputs (di*, dift, divc, dica) pass through 2-flop synchronizers before any use.
- Completion: valid = every group exactly one-hot, AND dift one-hot, AND divc one-hot.
- Spacer (empty) = all rails 0.
- Any other code is incomplete: wait, do not capture.
- Decode: data[2i+1:2i] = 0/1/2/3 for rail di0/di1/di2/di3 hot.
- Rx FSM:
  - IDLE: if valid for 2 consecutive synchronized cycles and FIFO not full -> CAPT.
  - CAPT: push {data, ft, vc}, set dia=1 -> WAITRTZ.
  - WAITRTZ: when spacer seen for 2 consecutive cycles, dia=0 -> IDLE.
- Each flit is pushed exactly once. dia never toggles twice within a handshake.
- FIFO:
  - Head entry drives fdata/fft/fvc; fvalid = !empty.
  - Pop when fvalid and fready.
  - Push and pop may occur in the same cycle; count unchanged and no loss, including when full (pop frees the slot first).
  - Pointers wrap modulo DEPTH.
  - Full blocks IDLE->CAPT only; dia stays low.
- Credit return, per VC v:
  - A pop of a flit with fvc[v] increments pend[v]. Width clog2(DEPTH)+1, saturates never; pend[v] <= DEPTH is guaranteed by upstream credits.
  - Per-VC FSM:
    - CIDLE: if pend[v]>0 (or a pop this cycle), dic[v]=1 -> CREQ.
    - CREQ: on synced dica[v]=1, dic[v]=0 and decrement pend[v] -> CRTZ.
    - CRTZ: on synced dica[v]=0 -> CIDLE.
  - Simultaneous pop and decrement on the same VC: pend[v] unchanged.
  - VCs operate independently and concurrently.
- Latency:
  - Rails stable to dia rise: 4 cycles (2 sync + 2 stability).
  - Push to fvalid: 1 cycle (registered FIFO).
  - Pop to dic rise: 1 cycle.
- Reset (async, any state, mid-handshake included):
  - dia=0, dic=0, FIFO empty, fvalid=0, fdata=0, fft=0, fvc=0, pend=0, all FSMs idle, synchronizers cleared.
  - Leaving reset with rails still valid is treated as a new flit.

Test Plan:
- Single flit, VCN=1, DW=32: drive rails encoding 0xA5A5_1234, dift=3'b001, divc=1 -> dia rises 4 cycles later; fdata=0xA5A51234, fft=001, fvalid=1; rails to spacer -> dia falls.
- Backpressure, DEPTH=4, fready=0: send 5 flits -> 4 pushed, 5th held with dia=0; one pop -> 5th captured; FIFO order preserved and no dic before the first pop.
- Credits, VCN=2: pop 3 flits on vc=2'b10 -> exactly 3 complete dic[1] 4-phase cycles, dic[0] stays 0; dica[1] slow (10-cycle delay) -> pend[1] reaches 3 then drains to 0.
- Concurrent push and pop while full (fready=1 continuously, back-to-back flits) -> count stays 4, no drop or duplicate, pointer wrap verified over 12 flits.
- Invalid/partial codes: two rails hot in group 3, or dift=0 -> no capture, dia=0; correcting the rails -> normal capture.
- Reset mid-handshake (in WAITRTZ with dic=1) -> all outputs 0 immediately; after release with spacer inputs, a new flit is received normally.

Source files
------------

// File: rtl/ni_ejector_if.sv
// rtl/ni_ejector_if.sv - QDI flit ingress, credit return and clocked flit egress bundle
// master drives the router rails, credit acks and consumer ready; slave is the ejector.
interface ni_ejector_if #(
    parameter int DW  = 32,
    parameter int FT  = 3,
    parameter int VCN = 1
);
    localparam int SCN = DW / 2;

    logic [SCN-1:0] di0;
    logic [SCN-1:0] di1;
    logic [SCN-1:0] di2;
    logic [SCN-1:0] di3;
    logic [FT-1:0]  dift;
    logic [VCN-1:0] divc;
    logic           dia;
    logic [VCN-1:0] dic;
    logic [VCN-1:0] dica;
    logic [DW-1:0]  fdata;
    logic [FT-1:0]  fft;
    logic [VCN-1:0] fvc;
    logic           fvalid;
    logic           fready;

    modport master (
        output di0, di1, di2, di3, dift, divc, dica, fready,
        input  dia, dic, fdata, fft, fvc, fvalid
    );

    modport slave (
        input  di0, di1, di2, di3, dift, divc, dica, fready,
        output dia, dic, fdata, fft, fvc, fvalid
    );
endinterface

// File: rtl/ni_ejector.sv
// rtl/ni_ejector.sv - QDI 1-of-4 flit receiver with flit FIFO and per-VC 4-phase credit return
// Rails are synchronized, checked for completion, decoded and queued toward the clocked NI.
module ni_ejector #(
    parameter int DW    = 32,
    parameter int SCN   = DW / 2,
    parameter int FT    = 3,
    parameter int VCN   = 1,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    ni_ejector_if.slave  ni_io
);
    localparam int AW = 4 * SCN + FT + 2 * VCN;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = DW + FT + VCN;

    typedef enum logic [1:0] {RX_IDLE, RX_CAPT, RX_WAIT} rx_e;
    typedef enum logic [1:0] {C_IDLE, C_REQ, C_RTZ} cr_e;

    logic [AW-1:0]  async_w;
    logic [AW-1:0]  sync1_q;
    logic [AW-1:0]  sync2_q;
    logic [SCN-1:0] s0, s1, s2, s3;
    logic [FT-1:0]  sft;
    logic [VCN-1:0] svc;
    logic [VCN-1:0] sca;

    assign async_w = {ni_io.dica, ni_io.divc, ni_io.dift, ni_io.di3, ni_io.di2, ni_io.di1, ni_io.di0};
    assign {sca, svc, sft, s3, s2, s1, s0} = sync2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= async_w;
            sync2_q <= sync1_q;
        end
    end

    logic          grp_ok_w;
    logic          valid_w;
    logic          spacer_w;
    logic [DW-1:0] data_w;

    // Rail di1/di2/di3 hot encodes 1/2/3, so bit1 = di2|di3 and bit0 = di1|di3.
    always_comb begin
        grp_ok_w = 1'b1;
        data_w   = '0;
        for (int i = 0; i < SCN; i++) begin
            if (!$onehot({s3[i], s2[i], s1[i], s0[i]})) grp_ok_w = 1'b0;
            data_w[2*i+1] = s3[i] | s2[i];
            data_w[2*i]   = s3[i] | s1[i];
        end
    end

    assign valid_w  = grp_ok_w && $onehot(sft) && $onehot(svc);
    assign spacer_w = ~|{svc, sft, s3, s2, s1, s0};

    logic [EW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [EW-1:0] head_w;
    logic [VCN-1:0] head_vc_w;
    logic          full_w, empty_w, pop_w, push_w;
    rx_e           rx_q;
    logic          dia_q;
    logic          valid_prev_q;
    logic          spacer_prev_q;

    assign head_w    = mem_q[rptr_q];
    assign head_vc_w = head_w[DW+FT +: VCN];
    assign full_w    = (cnt_q == CW'(DEPTH));
    assign empty_w   = (cnt_q == '0);
    assign pop_w     = !empty_w && ni_io.fready;
    // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
    assign push_w    = (rx_q == RX_IDLE) && valid_w && valid_prev_q && (!full_w || pop_w);

    always_comb begin
        cnt_d = cnt_q;
        if (push_w && !pop_w) cnt_d = cnt_q + CW'(1);
        else if (pop_w && !push_w) cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_w) begin
                mem_q[wptr_q] <= {svc, sft, data_w};
                wptr_q        <= wptr_q + PW'(1);
            end
            if (pop_w) rptr_q <= rptr_q + PW'(1);
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_q          <= RX_IDLE;
            dia_q         <= 1'b0;
            valid_prev_q  <= 1'b0;
            spacer_prev_q <= 1'b0;
        end else begin
            valid_prev_q  <= valid_w;
            spacer_prev_q <= spacer_w;
            case (rx_q)
                RX_IDLE: if (push_w) begin
                    dia_q <= 1'b1;
                    rx_q  <= RX_CAPT;
                end
                RX_CAPT: rx_q <= RX_WAIT;
                RX_WAIT: if (spacer_w && spacer_prev_q) begin
                    dia_q <= 1'b0;
                    rx_q  <= RX_IDLE;
                end
                default: rx_q <= RX_IDLE;
            endcase
        end
    end

    logic [CW-1:0]  pend_q [VCN];
    logic [CW-1:0]  pend_d [VCN];
    cr_e            cst_q  [VCN];
    logic [VCN-1:0] dic_q;
    logic [VCN-1:0] inc_w;
    logic [VCN-1:0] dec_w;

    always_comb begin
        for (int v = 0; v < VCN; v++) begin
            inc_w[v]  = pop_w && head_vc_w[v];
            dec_w[v]  = (cst_q[v] == C_REQ) && sca[v];
            pend_d[v] = pend_q[v] + CW'(inc_w[v]) - CW'(dec_w[v]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < VCN; v++) begin
                pend_q[v] <= '0;
                cst_q[v]  <= C_IDLE;
            end
            dic_q <= '0;
        end else begin
            for (int v = 0; v < VCN; v++) begin
                pend_q[v] <= pend_d[v];
                case (cst_q[v])
                    C_IDLE: if (pend_q[v] != '0 || inc_w[v]) begin
                        dic_q[v] <= 1'b1;
                        cst_q[v] <= C_REQ;
                    end
                    C_REQ: if (sca[v]) begin
                        dic_q[v] <= 1'b0;
                        cst_q[v] <= C_RTZ;
                    end
                    C_RTZ: if (!sca[v]) cst_q[v] <= C_IDLE;
                    default: cst_q[v] <= C_IDLE;
                endcase
            end
        end
    end

    assign ni_io.fdata  = head_w[DW-1:0];
    assign ni_io.fft    = head_w[DW +: FT];
    assign ni_io.fvc    = head_vc_w;
    assign ni_io.fvalid = !empty_w;
    assign ni_io.dia    = dia_q;
    assign ni_io.dic    = dic_q;
endmodule

// File: tb/tb_ni_ejector.sv
// tb/tb_ni_ejector.sv - directed bench for ni_ejector with a flit-queue and credit-ledger model
// The model tracks rail stability, queue occupancy and owed credits from the protocol rules.
module tb_ni_ejector;
    localparam int DW    = 32;
    localparam int SCN   = DW / 2;
    localparam int FT    = 3;
    localparam int VCN   = 2;
    localparam int DEPTH = 4;
    localparam int RW    = 4 * SCN + FT + VCN;

    typedef logic [DW+FT+VCN-1:0] ent_t;
    typedef logic [RW-1:0]        rails_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ni_ejector_if #(.DW(DW), .FT(FT), .VCN(VCN)) ifc();

    ni_ejector #(.DW(DW), .SCN(SCN), .FT(FT), .VCN(VCN), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .ni_io (ifc)
    );

    int     n_vec = 0;
    int     n_err = 0;
    ent_t   exp_q[$];
    rails_t m_rails = '0;
    int     m_age = 0;
    bit     m_wait = 1'b0;
    int     m_pops[2] = '{0, 0};
    int     dic_rises[2] = '{0, 0};
    logic [1:0] dic_prev = 2'b00;

    // Credit responder per VC: VC1 answers slowly to let owed credits pile up.
    for (genvar g = 0; g < VCN; g++) begin : g_agent
        localparam int DLY = (g == 1) ? 10 : 2;
        logic r = 1'b0;
        int   cnt = 0;
        initial forever begin
            @(negedge clk);
            if (rst) begin
                r   = 1'b0;
                cnt = 0;
            end else if (ifc.dic[g] && !r) begin
                for (int k = 0; k < DLY && !rst; k++) @(negedge clk);
                if (!rst && ifc.dic[g]) r = 1'b1;
            end else if (!ifc.dic[g] && r) begin
                for (int k = 0; k < DLY && !rst; k++) @(negedge clk);
                if (!rst) begin
                    r   = 1'b0;
                    cnt = cnt + 1;
                end
            end
        end
    end
    assign ifc.dica = {g_agent[1].r, g_agent[0].r};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    function automatic rails_t rails_now();
        return {ifc.divc, ifc.dift, ifc.di3, ifc.di2, ifc.di1, ifc.di0};
    endfunction

    function automatic bit rails_ok(input rails_t r);
        bit ok = ($countones(r[4*SCN +: FT]) == 1) && ($countones(r[4*SCN+FT +: VCN]) == 1);
        for (int i = 0; i < SCN; i++)
            if ($countones({r[3*SCN+i], r[2*SCN+i], r[SCN+i], r[i]}) != 1) ok = 1'b0;
        return ok;
    endfunction

    function automatic ent_t rails_decode(input rails_t r);
        logic [DW-1:0] d = '0;
        for (int i = 0; i < SCN; i++) begin
            if (r[SCN+i])        d[2*i +: 2] = 2'd1;
            else if (r[2*SCN+i]) d[2*i +: 2] = 2'd2;
            else if (r[3*SCN+i]) d[2*i +: 2] = 2'd3;
        end
        return {r[4*SCN+FT +: VCN], r[4*SCN +: FT], d};
    endfunction

    // Model: a flit is taken once its rails have been steady for 4 edges and there is room.
    initial forever begin
        rails_t cur;
        ent_t   e;
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            m_rails = '0;
            m_age   = 0;
            m_wait  = 1'b0;
            m_pops  = '{0, 0};
        end else begin
            cur = rails_now();
            if (cur !== m_rails) begin
                m_rails = cur;
                m_age   = 1;
            end else begin
                m_age++;
            end
            if (exp_q.size() > 0 && ifc.fready) begin
                e = exp_q.pop_front();
                if (e[DW+FT])   m_pops[0]++;
                if (e[DW+FT+1]) m_pops[1]++;
            end
            if (!m_wait) begin
                if (rails_ok(cur) && m_age >= 4 && exp_q.size() < DEPTH) begin
                    exp_q.push_back(rails_decode(cur));
                    m_wait = 1'b1;
                end
            end else if (cur == '0 && m_age >= 4) begin
                m_wait = 1'b0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst) begin
            chk("rst_dia", ifc.dia, 0);
            chk("rst_dic", ifc.dic, 0);
            chk("rst_fvalid", ifc.fvalid, 0);
            chk("rst_fdata", ifc.fdata, 0);
        end else begin
            chk("dia", ifc.dia, m_wait);
            chk("fvalid", ifc.fvalid, exp_q.size() > 0);
            if (exp_q.size() > 0) begin
                chk("fdata", ifc.fdata, exp_q[0][DW-1:0]);
                chk("fft", ifc.fft, exp_q[0][DW +: FT]);
                chk("fvc", ifc.fvc, exp_q[0][DW+FT +: VCN]);
            end
            if (ifc.dic[0]) chk("dic0_owed", (m_pops[0] - g_agent[0].cnt) > 0, 1);
            if (ifc.dic[1]) chk("dic1_owed", (m_pops[1] - g_agent[1].cnt) > 0, 1);
        end
        for (int v = 0; v < VCN; v++)
            if (ifc.dic[v] && !dic_prev[v]) dic_rises[v]++;
        dic_prev = ifc.dic;
    end

    task automatic set_rails(input logic [31:0] d, input logic [2:0] ft, input logic [1:0] vc);
        for (int i = 0; i < SCN; i++) begin
            ifc.di0[i] = (d[2*i +: 2] == 2'd0);
            ifc.di1[i] = (d[2*i +: 2] == 2'd1);
            ifc.di2[i] = (d[2*i +: 2] == 2'd2);
            ifc.di3[i] = (d[2*i +: 2] == 2'd3);
        end
        ifc.dift = ft;
        ifc.divc = vc;
    endtask

    task automatic spacer();
        ifc.di0 = '0; ifc.di1 = '0; ifc.di2 = '0; ifc.di3 = '0;
        ifc.dift = '0; ifc.divc = '0;
    endtask

    task automatic wait_dia(input logic lvl, input string nm);
        int k = 0;
        while (ifc.dia !== lvl && k < 60) begin
            @(negedge clk);
            k++;
        end
        n_vec++;
        if (ifc.dia !== lvl) begin
            n_err++;
            $display("FAIL %s: dia=%b after %0d cycles, required %b", nm, ifc.dia, k, lvl);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic [2:0] ft, input logic [1:0] vc);
        @(negedge clk);
        set_rails(d, ft, vc);
        @(negedge clk);
        wait_dia(1'b1, "send_ack");
        spacer();
        @(negedge clk);
        wait_dia(1'b0, "send_rtz");
    endtask

    task automatic pop_one(input logic [31:0] d, input string nm);
        int k = 0;
        while (!ifc.fvalid && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk(nm, ifc.fdata, d);
        ifc.fready = 1'b1;
        @(negedge clk);
        ifc.fready = 1'b0;
    endtask

    task automatic wait_credits(input string nm);
        int k = 0;
        while ((g_agent[0].cnt != m_pops[0] || g_agent[1].cnt != m_pops[1] ||
                ifc.dic != 2'b00 || ifc.dica != 2'b00) && k < 800) begin
            @(negedge clk);
            k++;
        end
        n_vec++;
        if (g_agent[0].cnt != m_pops[0] || g_agent[1].cnt != m_pops[1] || ifc.dic != 2'b00) begin
            n_err++;
            $display("FAIL %s: credits returned %0d/%0d, required %0d/%0d", nm,
                     g_agent[0].cnt, g_agent[1].cnt, m_pops[0], m_pops[1]);
        end
    endtask

    initial begin
        int b0, b1, bc1;
        spacer();
        ifc.fready = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;

        // Single flit: ack exactly 4 edges after the rails settle.
        @(negedge clk);
        set_rails(32'hA5A5_1234, 3'b001, 2'b01);
        repeat (3) @(negedge clk);
        chk("t1_dia_early", ifc.dia, 0);
        @(negedge clk);
        chk("t1_dia_rise", ifc.dia, 1);
        chk("t1_fdata", ifc.fdata, 32'hA5A5_1234);
        chk("t1_fft", ifc.fft, 3'b001);
        chk("t1_fvalid", ifc.fvalid, 1);
        spacer();
        repeat (3) @(negedge clk);
        chk("t1_dia_hold", ifc.dia, 1);
        @(negedge clk);
        chk("t1_dia_fall", ifc.dia, 0);
        ifc.fready = 1'b1;
        @(negedge clk);
        ifc.fready = 1'b0;
        chk("t1_dic", ifc.dic, 2'b01);
        chk("t1_empty", ifc.fvalid, 0);
        wait_credits("t1_credits");

        // Incomplete codes must not be captured until corrected.
        @(negedge clk);
        set_rails(32'h0000_0000, 3'b010, 2'b10);
        ifc.di1[3] = 1'b1;
        repeat (12) @(negedge clk);
        chk("inv_grp_dia", ifc.dia, 0);
        chk("inv_grp_fvalid", ifc.fvalid, 0);
        ifc.di1[3] = 1'b0;
        wait_dia(1'b1, "inv_grp_fix");
        spacer();
        wait_dia(1'b0, "inv_grp_rtz");
        @(negedge clk);
        set_rails(32'h5555_AAAA, 3'b000, 2'b01);
        repeat (12) @(negedge clk);
        chk("inv_ft_dia", ifc.dia, 0);
        ifc.dift = 3'b100;
        wait_dia(1'b1, "inv_ft_fix");
        spacer();
        wait_dia(1'b0, "inv_ft_rtz");
        pop_one(32'h0000_0000, "inv_pop0");
        pop_one(32'h5555_AAAA, "inv_pop1");
        wait_credits("inv_credits");

        // Backpressure: 5th flit waits for a slot; no credit before the first pop.
        for (int k = 0; k < 4; k++)
            send(32'h1111_0000 + k, 3'(1 << (k % 3)), (k % 2 == 1) ? 2'b10 : 2'b01);
        @(negedge clk);
        set_rails(32'h1111_0004, 3'b100, 2'b01);
        repeat (15) @(negedge clk);
        chk("bp_hold_dia", ifc.dia, 0);
        chk("bp_fvalid", ifc.fvalid, 1);
        chk("bp_no_credit", ifc.dic, 2'b00);
        pop_one(32'h1111_0000, "bp_pop0");
        wait_dia(1'b1, "bp_5th_ack");
        spacer();
        wait_dia(1'b0, "bp_5th_rtz");
        for (int k = 1; k < 5; k++) pop_one(32'h1111_0000 + k, "bp_order");
        wait_credits("bp_credits");

        // Push and pop on the same edge while full, 12 times across pointer wrap.
        for (int k = 0; k < 4; k++) send(32'hC0DE_0000 + k, 3'b010, 2'b01);
        for (int k = 4; k < 16; k++) begin
            @(negedge clk);
            set_rails(32'hC0DE_0000 + k, 3'b010, 2'b01);
            repeat (6) @(negedge clk);
            chk("full_hold", ifc.dia, 0);
            ifc.fready = 1'b1;
            @(negedge clk);
            ifc.fready = 1'b0;
            chk("full_swap_dia", ifc.dia, 1);
            chk("full_swap_valid", ifc.fvalid, 1);
            spacer();
            @(negedge clk);
            wait_dia(1'b0, "full_rtz");
        end
        for (int k = 12; k < 16; k++) pop_one(32'hC0DE_0000 + k, "full_order");
        wait_credits("full_credits");

        // Three pops on VC1 with a slow acker give exactly three credit handshakes.
        b0  = dic_rises[0];
        b1  = dic_rises[1];
        bc1 = g_agent[1].cnt;
        for (int k = 0; k < 3; k++) send(32'hBEEF_0000 + k, 3'b010, 2'b10);
        @(negedge clk);
        ifc.fready = 1'b1;
        repeat (3) @(negedge clk);
        ifc.fready = 1'b0;
        chk("cr_drained", ifc.fvalid, 0);
        chk("cr_dic_up", ifc.dic, 2'b10);
        repeat (150) @(negedge clk);
        chk("cr_vc1_cycles", dic_rises[1] - b1, 3);
        chk("cr_vc0_idle", dic_rises[0] - b0, 0);
        chk("cr_vc1_acks", g_agent[1].cnt - bc1, 3);
        wait_credits("cr_credits");

        // Reset while the receiver waits for return-to-zero and a credit is requested.
        send(32'h0BAD_0001, 3'b001, 2'b10);
        @(negedge clk);
        set_rails(32'h0BAD_0002, 3'b100, 2'b10);
        ifc.fready = 1'b1;
        @(negedge clk);
        ifc.fready = 1'b0;
        wait_dia(1'b1, "rst_pre_ack");
        chk("rst_pre_dic", ifc.dic, 2'b10);
        #2 rst = 1'b1;
        #1;
        chk("rst_now_dia", ifc.dia, 0);
        chk("rst_now_dic", ifc.dic, 0);
        chk("rst_now_fvalid", ifc.fvalid, 0);
        chk("rst_now_fdata", ifc.fdata, 0);
        chk("rst_now_fft", ifc.fft, 0);
        chk("rst_now_fvc", ifc.fvc, 0);
        spacer();
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        send(32'h600D_F00D, 3'b001, 2'b01);
        chk("rst_after_fft", ifc.fft, 3'b001);
        pop_one(32'h600D_F00D, "rst_after_data");
        wait_credits("final_credits");

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
